// File: rtl/axis_spi_dac_pkg.sv
// Shared types and defaults for the AXI4-Stream to SPI DAC transmitter.
package axis_spi_dac_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } state_e;

  localparam int unsigned DefDataW   = 16;
  localparam int unsigned DefClkDiv  = 10;
  localparam int unsigned DefCsSetup = 2;
  localparam int unsigned DefCsHold  = 2;
  localparam int unsigned DefCsIdle  = 4;
  localparam int unsigned LdacW      = 2;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period tick generator: while enabled, pulses tick for one cycle every CLK_DIV cycles.
module sclk_tick_gen #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;

  assign tick = en && (cnt_q == CntW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || !en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/axis_spi_dac_tx.sv
// AXIS slave to SPI mode 0 DAC writer: one word per CS_N frame, MSB first, with CS timing.
// Optional DAC_LDAC_EN adds an ldac_n strobe pulsed low at the start of the inter-frame gap.
module axis_spi_dac_tx
  import axis_spi_dac_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned CLK_DIV  = DefClkDiv,
  parameter int unsigned CS_SETUP = DefCsSetup,
  parameter int unsigned CS_HOLD  = DefCsHold,
  parameter int unsigned CS_IDLE  = DefCsIdle
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  output logic              busy
`ifdef DAC_LDAC_EN
  ,
  output logic              ldac_n
`endif
);

  localparam int unsigned MaxCs = max3(CS_SETUP, CS_HOLD, CS_IDLE);
  localparam int unsigned CntW  = $clog2(MaxCs + 1);
  localparam int unsigned BitW  = $clog2(DATA_W + 1);

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [BitW-1:0]   bit_q;
  // MSB goes straight to mosi at the handshake, so only the remaining bits are kept.
  logic [DATA_W-2:0] shreg_q;
  logic              tick;

  assign s_axis_tready = (state_q == StIdle) && !reset;
  assign busy          = (state_q != StIdle);

  sclk_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (state_q == StShift),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_axis_tvalid) begin
            shreg_q  <= s_axis_tdata[DATA_W-2:0];
            spi_mosi <= s_axis_tdata[DATA_W-1];
            spi_cs_n <= 1'b0;
            cnt_q    <= '0;
            state_q  <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == CntW'(CS_SETUP - 1)) begin
            cnt_q   <= '0;
            state_q <= StShift;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StShift: begin
          if (tick) begin
            spi_sclk <= ~spi_sclk;
            if (!spi_sclk) begin
              bit_q <= bit_q + 1'b1;
            end else if (bit_q == BitW'(DATA_W)) begin
              bit_q    <= '0;
              spi_mosi <= 1'b0;
              state_q  <= StHold;
            end else begin
              spi_mosi <= shreg_q[DATA_W-2];
              shreg_q  <= {shreg_q[DATA_W-3:0], 1'b0};
            end
          end
        end
        StHold: begin
          if (cnt_q == CntW'(CS_HOLD - 1)) begin
            cnt_q    <= '0;
            spi_cs_n <= 1'b1;
            state_q  <= StGap;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == CntW'(CS_IDLE - 1)) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DAC_LDAC_EN
  // Low for the first LdacW cycles of the gap, i.e. starting the edge after cs_n rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      ldac_n <= 1'b1;
    end else begin
      ldac_n <= !((state_q == StGap) && (32'(cnt_q) < LdacW));
    end
  end
`endif

endmodule

// File: tb/tb_axis_spi_dac_tx.sv
// Scoreboard bench for axis_spi_dac_tx: default-timing and minimum-timing instances.
module tb_axis_spi_dac_tx;

`ifdef DAC_LDAC_EN
  localparam int FastIdle = 2;
`else
  localparam int FastIdle = 1;
`endif
  // Per instance: cs_n low span, tready return, first rise offset, rise-to-rise period, CS_IDLE.
  localparam int LoExp[2]    = '{324, 34};
  localparam int RdyExp[2]   = '{328, 34 + FastIdle};
  localparam int FirstExp[2] = '{12, 2};
  localparam int PerExp[2]   = '{20, 2};
  localparam int IdleExp[2]  = '{4, FastIdle};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] tdata0 = '0, tdata1 = '0;
  logic        tvalid0 = 1'b0, tvalid1 = 1'b0;
  wire  [1:0]  tready, cs_n, sclk, mosi, busy;
`ifdef DAC_LDAC_EN
  wire  [1:0]  ldac_n;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  axis_spi_dac_tx u_dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_tdata (tdata0),
    .s_axis_tvalid(tvalid0),
    .s_axis_tready(tready[0]),
    .spi_cs_n     (cs_n[0]),
    .spi_sclk     (sclk[0]),
    .spi_mosi     (mosi[0]),
    .busy         (busy[0])
`ifdef DAC_LDAC_EN
    ,
    .ldac_n       (ldac_n[0])
`endif
  );

  axis_spi_dac_tx #(
    .DATA_W  (16),
    .CLK_DIV (1),
    .CS_SETUP(1),
    .CS_HOLD (1),
    .CS_IDLE (FastIdle)
  ) u_fast (
    .clk          (clk),
    .reset        (reset),
    .s_axis_tdata (tdata1),
    .s_axis_tvalid(tvalid1),
    .s_axis_tready(tready[1]),
    .spi_cs_n     (cs_n[1]),
    .spi_sclk     (sclk[1]),
    .spi_mosi     (mosi[1]),
    .busy         (busy[1])
`ifdef DAC_LDAC_EN
    ,
    .ldac_n       (ldac_n[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor state, indexed by instance.
  int   fall_c[2], crise_c[2], first_r[2], last_r[2], nrise[2], ld_first[2], ld_cnt[2];
  logic [15:0] shin[2];
  bit   in_frame[2], pend_rdy[2], bad[2], seen_frame[2];
  logic p_cs[2] = '{1'b1, 1'b1};
  logic p_sc[2], p_mo[2], p_rd[2];

  task automatic mon(input int d, input logic cs, input logic sc, input logic mo, input logic rd,
                     input logic ld);
    logic [15:0] w;
    bit have;
    if (reset) begin
      in_frame[d] = 0;
      pend_rdy[d] = 0;
      seen_frame[d] = 0;
    end else begin
      if (p_cs[d] && !cs) begin
        if (seen_frame[d]) chk($sformatf("cs_idle%0d", d), 32'(cyc - crise_c[d] >= IdleExp[d]), 1);
        in_frame[d] = 1;
        fall_c[d] = cyc;
        nrise[d] = 0;
        shin[d] = '0;
        bad[d] = 0;
        first_r[d] = -1;
      end
      if (in_frame[d] && sc && !p_sc[d]) begin
        if (nrise[d] == 0) first_r[d] = cyc - fall_c[d];
        else if (cyc - last_r[d] != PerExp[d]) bad[d] = 1;
        last_r[d] = cyc;
        shin[d] = {shin[d][14:0], mo};
        nrise[d]++;
      end
      if (sc && p_sc[d] && mo !== p_mo[d]) bad[d] = 1;
      if (cs && sc) bad[d] = 1;
      if (in_frame[d] && !p_cs[d] && cs) begin
        have = 0;
        w = '0;
        if (d == 0 && exp_q0.size() > 0) begin have = 1; w = exp_q0.pop_front(); end
        if (d == 1 && exp_q1.size() > 0) begin have = 1; w = exp_q1.pop_front(); end
        chk($sformatf("frame_expected%0d", d), 32'(have), 1);
        if (have) chk($sformatf("word%0d", d), 32'(shin[d]), 32'(w));
        chk($sformatf("rises%0d", d), nrise[d], 16);
        chk($sformatf("cs_low%0d", d), cyc - fall_c[d], LoExp[d]);
        chk($sformatf("first_rise%0d", d), first_r[d], FirstExp[d]);
        chk($sformatf("sclk_mosi_clean%0d", d), 32'(bad[d]), 0);
        in_frame[d] = 0;
        pend_rdy[d] = 1;
        seen_frame[d] = 1;
        crise_c[d] = cyc;
        ld_cnt[d] = 0;
        ld_first[d] = -1;
      end
`ifdef DAC_LDAC_EN
      if (!ld) begin
        if (pend_rdy[d]) begin
          if (ld_cnt[d] == 0) ld_first[d] = cyc - crise_c[d];
          ld_cnt[d]++;
        end else begin
          chk($sformatf("ldac_stray%0d", d), 32'(ld), 1);
        end
      end
`endif
      if (pend_rdy[d] && rd && !p_rd[d]) begin
        chk($sformatf("ready_return%0d", d), cyc - fall_c[d], RdyExp[d]);
`ifdef DAC_LDAC_EN
        chk($sformatf("ldac_start%0d", d), ld_first[d], 1);
        chk($sformatf("ldac_len%0d", d), ld_cnt[d], 2);
`endif
        pend_rdy[d] = 0;
      end
    end
    p_cs[d] = cs;
    p_sc[d] = sc;
    p_mo[d] = mo;
    p_rd[d] = rd;
  endtask

  always @(negedge clk) begin
`ifdef DAC_LDAC_EN
    mon(0, cs_n[0], sclk[0], mosi[0], tready[0], ldac_n[0]);
    mon(1, cs_n[1], sclk[1], mosi[1], tready[1], ldac_n[1]);
`else
    mon(0, cs_n[0], sclk[0], mosi[0], tready[0], 1'b1);
    mon(1, cs_n[1], sclk[1], mosi[1], tready[1], 1'b1);
`endif
  end

  task automatic offer(input int d, input logic [15:0] w);
    if (d == 0) begin tdata0 = w; tvalid0 = 1'b1; exp_q0.push_back(w); end
    else begin tdata1 = w; tvalid1 = 1'b1; exp_q1.push_back(w); end
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (tready[d] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (tready[d] !== 1'b1) chk($sformatf("ready_timeout%0d", d), 32'(tready[d]), 1);
  endtask

  // Returns at the negedge after the handshake edge; e0 is that edge's cycle number.
  task automatic wait_hs(input int d, output int e0);
    wait_ready(d);
    @(negedge clk);
    e0 = cyc;
  endtask

  task automatic send(input int d, input logic [15:0] w);
    int e0;
    offer(d, w);
    wait_hs(d, e0);
    if (d == 0) tvalid0 = 1'b0; else tvalid1 = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tready"}, 32'(tready[0]), 0);
    chk({tag, "_busy"}, 32'(busy[0]), 0);
    chk({tag, "_cs_n"}, 32'(cs_n[0]), 1);
    chk({tag, "_sclk"}, 32'(sclk[0]), 0);
    chk({tag, "_mosi"}, 32'(mosi[0]), 0);
`ifdef DAC_LDAC_EN
    chk({tag, "_ldac_n"}, 32'(ldac_n[0]), 1);
`endif
  endtask

  initial begin
    int ea, eb, nr, n;
    logic ps;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);

    send(0, 16'hA5C3);
    wait_ready(0);

    // Back-to-back with tvalid held high across both words.
    offer(0, 16'hFFFF);
    wait_hs(0, ea);
    offer(0, 16'h0001);
    wait_hs(0, eb);
    tvalid0 = 1'b0;
    chk("b2b_period", eb - ea, 329);
    wait_ready(0);

    // Upstream noise during a frame must not disturb it.
    send(0, 16'h5A3C);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      tvalid0 = i[0];
      tdata0 = 16'(i * 16'h1111);
      if (i == 30) begin
        chk("busy_mid_frame", 32'(busy[0]), 1);
        chk("tready_mid_frame", 32'(tready[0]), 0);
      end
    end
    tvalid0 = 1'b0;
    wait_ready(0);

    // Reset at the 5th SCLK rise drops the word entirely.
    send(0, 16'hC0DE);
    nr = 0;
    n = 0;
    ps = sclk[0];
    while (nr < 5 && n < 2000) begin
      @(negedge clk);
      if (sclk[0] && !ps) nr++;
      ps = sclk[0];
      n++;
    end
    chk("fifth_rise_seen", nr, 5);
    void'(exp_q0.pop_back());
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(0, 16'h1234);
    wait_ready(0);

    // Minimum timing instance.
    send(1, 16'h8000);
    wait_ready(1);
    send(1, 16'h0F0F);
    wait_ready(1);
    send(0, 16'h0F0F);
    wait_ready(0);

    repeat (5) @(negedge clk);
    chk("queue0_drained", exp_q0.size(), 0);
    chk("queue1_drained", exp_q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
